serial_frame_recognizer: RTL and testbench

Parametrised serial-line recogniser that generalises the fixed 7-state LINEA recogniser to a programmable sync pattern, configurable payload length and an optional parity check. It samples one bit of LINEA per enabled clock, hunts for the sync word, deserialises the payload and checks parity. It then pulses U (good frame) or ERR (bad parity). It sits at the serial front end; DOUT and FRAME_CNT feed downstream control logic.

---
 rtl/serial_frame_recognizer.sv | 131 +++++++++++++
 tb/tb_serial_frame_recognizer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_recognizer.sv
// Serial-line frame recogniser: hunts for a programmable sync word, deserialises
// a fixed-length LSB-first payload, optionally checks parity, then pulses U or ERR.
module serial_frame_recognizer #(
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011,
  parameter int                  DATA_BITS    = 8,
  parameter bit                  PAR_EN       = 1'b1,
  parameter bit                  PAR_ODD      = 1'b0,
  parameter int                  CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EN,
  input  logic                 LINEA,
  output logic                 U,
  output logic                 ERR,
  output logic [DATA_BITS-1:0] DOUT,
  output logic [CNT_W-1:0]     FRAME_CNT,
  output logic                 BUSY
);

  localparam int FILL_W = $clog2(SYNC_LEN + 1);
  localparam int BC_W   = $clog2(DATA_BITS);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_LEN);
  localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(SYNC_LEN - 1);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_PAR} state_t;

  state_t               r_state;
  logic [SYNC_LEN-1:0]  r_sh;
  logic [FILL_W-1:0]    r_fill;
  logic [BC_W-1:0]      r_bitcnt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par;

  logic [SYNC_LEN-1:0]  w_cand;
  logic                 w_match;
  logic                 w_par_ok;
  logic [DATA_BITS-1:0] w_data_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The fill qualifier keeps the cleared shift register from matching patterns with zeros.
  assign w_cand   = {r_sh[SYNC_LEN-2:0], LINEA};
  assign w_match  = (r_fill >= FILL_THR) && (w_cand == SYNC_PATTERN);
  assign w_par_ok = ((r_par ^ LINEA) == PAR_ODD);

  always_comb begin
    w_data_nxt           = r_data;
    w_data_nxt[r_bitcnt] = LINEA;
  end

  always_ff @(posedge clk) begin
    if (EN && r_state == S_DATA) r_data <= w_data_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HUNT;
      r_sh      <= '0;
      r_fill    <= '0;
      r_bitcnt  <= '0;
      r_par     <= 1'b0;
      U         <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      DOUT      <= '0;
      FRAME_CNT <= '0;
    end else begin
      U   <= 1'b0;
      ERR <= 1'b0;
      if (EN) begin
        case (r_state)
          S_HUNT: begin
            r_sh <= w_cand;
            if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
            if (w_match) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
              BUSY     <= 1'b1;
            end
          end
          S_DATA: begin
            r_par <= r_par ^ LINEA;
            if (r_bitcnt == BIT_LAST) begin
              if (PAR_EN) begin
                r_state <= S_PAR;
              end else begin
                // Without a parity bit the last payload bit is the deciding bit.
                U         <= 1'b1;
                DOUT      <= w_data_nxt;
                FRAME_CNT <= sat_inc(FRAME_CNT);
                r_state   <= S_HUNT;
                BUSY      <= 1'b0;
                r_sh      <= '0;
                r_fill    <= '0;
                r_par     <= 1'b0;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          S_PAR: begin
            if (w_par_ok) begin
              U         <= 1'b1;
              DOUT      <= r_data;
              FRAME_CNT <= sat_inc(FRAME_CNT);
            end else begin
              ERR <= 1'b1;
            end
            r_state <= S_HUNT;
            BUSY    <= 1'b0;
            r_sh    <= '0;
            r_fill  <= '0;
            r_par   <= 1'b0;
          end
          default: begin
            r_state <= S_HUNT;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_recognizer.sv
// Bench for serial_frame_recognizer: table-driven frame, directed corner sequences
// and random bit streams checked against a queue-based frame model.
module tb_serial_frame_recognizer;

  localparam int         SYNC_LEN  = 4;
  localparam logic [3:0] SYNC_PAT  = 4'b1011;
  localparam int         DATA_BITS = 8;
  localparam bit         PAR_EN    = 1'b1;
  localparam bit         PAR_ODD   = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       EN = 1'b0;
  logic       LINEA = 1'b0;
  logic       U, ERR, BUSY;
  logic [7:0] DOUT, FRAME_CNT;
  logic       U2, ERR2, BUSY2;
  logic [7:0] DOUT2;
  logic [1:0] FRAME_CNT2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_frame_recognizer #(.SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(SYNC_PAT), .DATA_BITS(DATA_BITS),
    .PAR_EN(PAR_EN), .PAR_ODD(PAR_ODD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .EN(EN), .LINEA(LINEA), .U(U), .ERR(ERR),
    .DOUT(DOUT), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY));

  serial_frame_recognizer #(.SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(SYNC_PAT), .DATA_BITS(DATA_BITS),
    .PAR_EN(PAR_EN), .PAR_ODD(PAR_ODD), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .EN(EN), .LINEA(LINEA), .U(U2), .ERR(ERR2),
    .DOUT(DOUT2), .FRAME_CNT(FRAME_CNT2), .BUSY(BUSY2));

  // Frame model: recent-bit window while hunting, payload queue while inside a frame.
  bit         hist[$];
  bit         pay[$];
  bit         m_in;
  bit         m_u, m_err;
  logic [7:0] m_dout;
  int         m_cnt, m_cnt2;

  task automatic model_reset();
    hist.delete();
    pay.delete();
    m_in = 0; m_u = 0; m_err = 0;
    m_dout = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_decide(input bit ok);
    if (ok) begin
      m_u = 1;
      for (int i = 0; i < DATA_BITS; i++) m_dout[i] = pay[i];
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_err = 1;
    end
    m_in = 0;
    hist.delete();
    pay.delete();
  endtask

  task automatic model_step(input logic en, input logic b);
    int v;
    int ones;
    m_u = 0;
    m_err = 0;
    if (en) begin
      if (!m_in) begin
        hist.push_back(b);
        if (hist.size() > SYNC_LEN) void'(hist.pop_front());
        if (hist.size() == SYNC_LEN) begin
          v = 0;
          foreach (hist[i]) v = v * 2 + int'(hist[i]);
          if (v == int'(SYNC_PAT)) begin
            m_in = 1;
            pay.delete();
          end
        end
      end else if (pay.size() < DATA_BITS) begin
        pay.push_back(b);
        if (pay.size() == DATA_BITS && !PAR_EN) model_decide(1);
      end else begin
        ones = int'(b);
        foreach (pay[i]) ones += int'(pay[i]);
        model_decide((ones % 2) == int'(PAR_ODD));
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("U", {31'd0, U}, {31'd0, m_u});
    chk("ERR", {31'd0, ERR}, {31'd0, m_err});
    chk("BUSY", {31'd0, BUSY}, {31'd0, m_in});
    chk("DOUT", {24'd0, DOUT}, {24'd0, m_dout});
    chk("FRAME_CNT", {24'd0, FRAME_CNT}, m_cnt);
    chk("FRAME_CNT2", {30'd0, FRAME_CNT2}, m_cnt2);
    chk("U_ERR_excl", {31'd0, U & ERR}, 32'd0);
  endtask

  task automatic tick(input logic en, input logic b);
    EN = en;
    LINEA = b;
    @(posedge clk);
    model_step(en, b);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_U", {31'd0, U}, 32'd0);
    chk("rst_ERR", {31'd0, ERR}, 32'd0);
    chk("rst_BUSY", {31'd0, BUSY}, 32'd0);
    chk("rst_DOUT", {24'd0, DOUT}, 32'd0);
    chk("rst_CNT", {24'd0, FRAME_CNT}, 32'd0);
    chk("rst_CNT2", {30'd0, FRAME_CNT2}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_sync();
    for (int i = SYNC_LEN - 1; i >= 0; i--) tick(1'b1, SYNC_PAT[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb);
    send_sync();
    for (int i = 0; i < DATA_BITS; i++) tick(1'b1, d[i]);
    tick(1'b1, pb);
  endtask

  typedef struct packed {
    logic en;
    logic b;
    logic u;
    logic e;
    logic busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] a5;
    int         exp2;
    a5 = 8'hA5;
    // Good frame 1011 | 0xA5 LSB first | even parity 0, then one idle bit.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) tbl[4 + i] = '{1'b1, a5[i], 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    model_reset();
    do_reset();

    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].b);
      chk($sformatf("tbl_U[%0d]", i), {31'd0, U}, {31'd0, tbl[i].u});
      chk($sformatf("tbl_ERR[%0d]", i), {31'd0, ERR}, {31'd0, tbl[i].e});
      chk($sformatf("tbl_BUSY[%0d]", i), {31'd0, BUSY}, {31'd0, tbl[i].busy});
    end
    chk("good_DOUT", {24'd0, DOUT}, 32'hA5);
    chk("good_CNT", {24'd0, FRAME_CNT}, 32'd1);

    send_frame(8'hA5, 1'b1);
    chk("bad_ERR", {31'd0, ERR}, 32'd1);
    chk("bad_U", {31'd0, U}, 32'd0);
    chk("bad_DOUT", {24'd0, DOUT}, 32'hA5);
    chk("bad_CNT", {24'd0, FRAME_CNT}, 32'd1);
    tick(1'b1, 1'b0);
    chk("bad_ERR_gone", {31'd0, ERR}, 32'd0);

    // Overlapping hunt: 1010 must not match, 1011 ending on the sixth bit must.
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0);
    chk("ovl_nomatch", {31'd0, BUSY}, 32'd0);
    tick(1'b1, 1'b1);
    chk("ovl_nomatch5", {31'd0, BUSY}, 32'd0);
    tick(1'b1, 1'b1);
    chk("ovl_match6", {31'd0, BUSY}, 32'd1);
    d = 8'h3C;
    for (int i = 0; i < 8; i++) tick(1'b1, d[i]);
    tick(1'b1, 1'b0);
    chk("ovl_U", {31'd0, U}, 32'd1);
    chk("ovl_DOUT", {24'd0, DOUT}, 32'h3C);

    // EN held low mid-payload with the line toggling.
    d = 8'h5A;
    send_sync();
    for (int i = 0; i < 3; i++) tick(1'b1, d[i]);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, i[0]);
      chk("frz_BUSY", {31'd0, BUSY}, 32'd1);
      chk("frz_pulse", {30'd0, U, ERR}, 32'd0);
    end
    for (int i = 3; i < 8; i++) tick(1'b1, d[i]);
    tick(1'b1, 1'b0);
    chk("frz_U", {31'd0, U}, 32'd1);
    chk("frz_DOUT", {24'd0, DOUT}, 32'h5A);
    chk("frz_CNT", {24'd0, FRAME_CNT}, 32'd3);

    // Saturation of the 2-bit counter over five good frames.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      d = 8'h10 + 8'(k);
      send_frame(d, ^d ^ PAR_ODD);
      exp2 = (k + 1 > 3) ? 3 : k + 1;
      chk("sat_CNT2", {30'd0, FRAME_CNT2}, exp2);
      chk("sat_CNT8", {24'd0, FRAME_CNT}, k + 1);
    end

    // Reset during a payload discards the frame.
    send_sync();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    do_reset();
    tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    chk("abort_nopulse", {30'd0, U, ERR}, 32'd0);
    d = 8'hC3;
    send_frame(d, ^d);
    chk("abort_U", {31'd0, U}, 32'd1);
    chk("abort_CNT", {24'd0, FRAME_CNT}, 32'd1);
    chk("abort_DOUT", {24'd0, DOUT}, 32'hC3);

    // Random line with random strobes.
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
